// File: rtl/quad_step_decoder.sv
// Quadrature decoder: 2-FF sync, stability filter, INIT/TRACK step decode,
// up/down position counter with parallel load and sticky illegal-transition flag.
module quad_step_decoder #(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             A_in,
  input  logic             B_in,
  input  logic             Load,
  input  logic [WIDTH-1:0] Count_in,
  input  logic             Clear_err,
  output logic [WIDTH-1:0] Count_out,
  output logic             Up,
  output logic             Step,
  output logic             Err
);

  localparam logic [3:0]       FiltLen = 4'(FILTER_LEN);
  localparam logic [WIDTH-1:0] One     = WIDTH'(1);

  typedef enum logic {StInit, StTrack} state_e;

  state_e     state_q;
  logic [1:0] sync1_q, sync2_q;
  logic [1:0] cand_q, cand_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] code_q;
  logic [1:0] fwd_next, rev_next;
  logic       accept, fwd, rev;

  always_comb begin
    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = 4'd1;
    end else if (cnt_q < FiltLen) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Acceptance is decided on the edge the count reaches FILTER_LEN, so the
  // filtered code takes effect on that same edge rather than one later.
  assign accept = (cnt_d == FiltLen) && ((state_q == StInit) || (cand_d != code_q));

  always_comb begin
    fwd_next = 2'b00;
    rev_next = 2'b00;
    unique case (code_q)
      2'b00: begin fwd_next = 2'b01; rev_next = 2'b10; end
      2'b01: begin fwd_next = 2'b11; rev_next = 2'b00; end
      2'b11: begin fwd_next = 2'b10; rev_next = 2'b01; end
      2'b10: begin fwd_next = 2'b00; rev_next = 2'b11; end
      default: ;
    endcase
  end

  assign fwd = (cand_d == fwd_next);
  assign rev = (cand_d == rev_next);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q   <= 2'b00;
      sync2_q   <= 2'b00;
      cand_q    <= 2'b00;
      cnt_q     <= 4'd0;
      code_q    <= 2'b00;
      state_q   <= StInit;
      Count_out <= '0;
      Up        <= 1'b1;
      Step      <= 1'b0;
      Err       <= 1'b0;
    end else begin
      sync1_q <= {A_in, B_in};
      sync2_q <= sync1_q;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      Step    <= 1'b0;
      if (Clear_err) begin
        Err <= 1'b0;
      end
      if (accept) begin
        code_q <= cand_d;
        if (state_q == StInit) begin
          state_q <= StTrack;
        end else if (fwd) begin
          Up        <= 1'b1;
          Step      <= 1'b1;
          Count_out <= Count_out + One;
        end else if (rev) begin
          Up        <= 1'b0;
          Step      <= 1'b1;
          Count_out <= Count_out - One;
        end else begin
          Err <= 1'b1;
        end
      end
      // Load overrides any same-edge count update; Step/Up still report it.
      if (Load) begin
        Count_out <= Count_in;
      end
    end
  end

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: latency, direction, wrap, glitch
// rejection, error flag, load priority and reset behaviour.
module tb_quad_step_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       a, b;
  logic       load;
  logic [3:0] count_in;
  logic       clear_err;
  logic [3:0] count_out;
  logic       up, step, err;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [3:0] cur_count;
  int         steps_seen;

  quad_step_decoder #(
    .WIDTH     (4),
    .FILTER_LEN(3)
  ) dut (
    .Clk      (clk),
    .Reset    (rst),
    .A_in     (a),
    .B_in     (b),
    .Load     (load),
    .Count_in (count_in),
    .Clear_err(clear_err),
    .Count_out(count_out),
    .Up       (up),
    .Step     (step),
    .Err      (err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run n cycles, counting Step pulses.
  task automatic run_count(input int n);
    steps_seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (step === 1'b1) steps_seen++;
    end
  endtask

  // Drive a new pin code and check the result lands exactly 5 edges later.
  task automatic apply(input string tag, input logic [1:0] code, input logic do_load,
                       input logic [3:0] load_val, input logic do_clear, input logic exp_step,
                       input logic [3:0] exp_count, input logic exp_up, input logic exp_err);
    {a, b} = code;
    repeat (4) tick();
    check_eq({tag, " early step"}, step, 1'b0);
    check_eq({tag, " early count"}, count_out, cur_count);
    load      = do_load;
    count_in  = load_val;
    clear_err = do_clear;
    tick();
    load      = 1'b0;
    clear_err = 1'b0;
    check_eq({tag, " step"}, step, exp_step);
    check_eq({tag, " count"}, count_out, exp_count);
    check_eq({tag, " up"}, up, exp_up);
    check_eq({tag, " err"}, err, exp_err);
    cur_count = exp_count;
    repeat (5) tick();
    check_eq({tag, " step drop"}, step, 1'b0);
    check_eq({tag, " hold count"}, count_out, exp_count);
  endtask

  initial begin
    rst = 1'b1; a = 1'b1; b = 1'b1; load = 1'b0; count_in = 4'd0; clear_err = 1'b0;
    cur_count = 4'd0;

    // Reset with 11 held: INIT absorbs it
    repeat (2) tick();
    rst = 1'b0;
    check_eq("rst count", count_out, 4'd0);
    check_eq("rst up", up, 1'b1);
    check_eq("rst step", step, 1'b0);
    check_eq("rst err", err, 1'b0);
    run_count(10);
    check_eq("init11 steps", steps_seen, 0);
    check_eq("init11 err", err, 1'b0);
    check_eq("init11 count", count_out, 4'd0);

    // Re-enter INIT with 00 held, then forward cycle
    rst = 1'b1; a = 1'b0; b = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    run_count(10);
    check_eq("init00 steps", steps_seen, 0);
    apply("fwd01", 2'b01, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
    apply("fwd11", 2'b11, 1'b0, 4'd0, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    apply("fwd10", 2'b10, 1'b0, 4'd0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
    apply("fwd00", 2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 4'd4, 1'b1, 1'b0);

    // Load then reverse cycle, then wrap both ways
    load = 1'b1; count_in = 4'b1010;
    tick();
    load = 1'b0;
    check_eq("load 10", count_out, 4'd10);
    cur_count = 4'd10;
    apply("rev10", 2'b10, 1'b0, 4'd0, 1'b0, 1'b1, 4'd9, 1'b0, 1'b0);
    apply("rev11", 2'b11, 1'b0, 4'd0, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0);
    apply("rev01", 2'b01, 1'b0, 4'd0, 1'b0, 1'b1, 4'd7, 1'b0, 1'b0);
    apply("rev00", 2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 4'd6, 1'b0, 1'b0);
    load = 1'b1; count_in = 4'd0;
    tick();
    load = 1'b0;
    cur_count = 4'd0;
    apply("wrap dn", 2'b10, 1'b0, 4'd0, 1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    apply("wrap up", 2'b00, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 1'b1, 1'b0);

    // Glitches from 00: 2 cycles ignored, 4 cycles accepted (and its return too)
    a = 1'b1;
    repeat (2) tick();
    a = 1'b0;
    run_count(12);
    check_eq("glitch2 steps", steps_seen, 0);
    check_eq("glitch2 count", count_out, 4'd0);
    a = 1'b1;
    repeat (4) tick();
    a = 1'b0;
    tick();
    check_eq("glitch4 step", step, 1'b1);
    check_eq("glitch4 count", count_out, 4'd15);
    check_eq("glitch4 up", up, 1'b0);
    run_count(12);
    check_eq("glitch4 return steps", steps_seen, 1);
    check_eq("glitch4 return count", count_out, 4'd0);
    check_eq("glitch4 return up", up, 1'b1);
    cur_count = 4'd0;

    // Illegal transitions, set-beats-clear, then clear alone
    apply("ill 00-11", 2'b11, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
    apply("fwd after ill", 2'b10, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b1);
    apply("ill+clear", 2'b01, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check_eq("clear err", err, 1'b0);

    // Load on the exact step edge wins over the increment
    apply("load on step", 2'b11, 1'b1, 4'b0011, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);

    // Reset inside a pending filter window
    {a, b} = 2'b10;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check_eq("midrst count", count_out, 4'd0);
    check_eq("midrst up", up, 1'b1);
    check_eq("midrst step", step, 1'b0);
    check_eq("midrst err", err, 1'b0);
    rst = 1'b0;
    run_count(12);
    check_eq("midrst steps", steps_seen, 0);
    check_eq("midrst count after", count_out, 4'd0);
    check_eq("midrst err after", err, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
